// File: rtl/code_lock.sv
// code_lock: N-digit 2-bit symbol code checker with unlock/fail pulses,
// consecutive-failure counting and a timed lockout after MAX_FAIL failures.
module code_lock #(
  parameter int N_DIGITS = 4,
  parameter logic [2*N_DIGITS-1:0] CODE = 8'b00_11_01_10,
  parameter int MAX_FAIL = 3,
  parameter int LOCKOUT_CYCLES = 16
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       sym_valid,
  input  logic [1:0] sym,
  input  logic       clear,
  output logic       unlock,
  output logic       fail,
  output logic       locked_out,
  output logic [2:0] idx,
  output logic [1:0] fail_cnt
);
  localparam logic ENTRY   = 1'b0;
  localparam logic LOCKOUT = 1'b1;

  logic       r_state;
  logic [2:0] r_idx;
  logic       r_err;
  logic [1:0] r_fail_cnt;
  logic [7:0] r_timer;
  logic       r_unlock;
  logic       r_fail;
  logic [15:0] w_code;
  logic [1:0]  w_digit;
  logic        w_match;
  logic        w_last;
  logic        w_lock_now;

  // Zero-extend so the digit select stays in range for every idx value.
  assign w_code     = 16'(CODE);
  assign w_digit    = w_code[{r_idx, 1'b0} +: 2];
  assign w_match    = sym == w_digit;
  assign w_last     = r_idx == 3'(N_DIGITS - 1);
  assign w_lock_now = ({1'b0, r_fail_cnt} + 3'd1) == 3'(MAX_FAIL);

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state    <= ENTRY;
      r_idx      <= '0;
      r_err      <= 1'b0;
      r_fail_cnt <= '0;
      r_timer    <= '0;
      r_unlock   <= 1'b0;
      r_fail     <= 1'b0;
    end else begin
      r_unlock <= 1'b0;
      r_fail   <= 1'b0;
      if (r_state == ENTRY) begin
        if (clear) begin
          r_idx <= '0;
          r_err <= 1'b0;
        end else if (sym_valid && !w_last) begin
          r_idx <= r_idx + 3'd1;
          r_err <= r_err | ~w_match;
        end else if (sym_valid) begin
          r_idx <= '0;
          r_err <= 1'b0;
          if (!r_err && w_match) begin
            r_unlock   <= 1'b1;
            r_fail_cnt <= '0;
          end else if (w_lock_now) begin
            r_fail     <= 1'b1;
            r_fail_cnt <= '0;
            r_state    <= LOCKOUT;
            r_timer    <= 8'(LOCKOUT_CYCLES - 1);
          end else begin
            r_fail     <= 1'b1;
            r_fail_cnt <= r_fail_cnt + 2'd1;
          end
        end
      end else if (r_timer == 8'd0) begin
        r_state <= ENTRY;
      end else begin
        r_timer <= r_timer - 8'd1;
      end
    end
  end

  assign unlock     = r_unlock;
  assign fail       = r_fail;
  assign locked_out = r_state == LOCKOUT;
  assign idx        = r_idx;
  assign fail_cnt   = r_fail_cnt;
endmodule

// File: doc/code_lock.md
Name: code_lock

Overview:
- Sequential stage directly downstream of the team's 2-bit equality comparator.
- Accepts a stream of 2-bit symbols and checks each one against a stored N-digit code, one eq2-style compare per digit.
- Tracks entry progress, produces a one-cycle unlock pulse on a correct full sequence, and counts failed attempts.
- Enforces a timed lockout after MAX_FAIL consecutive failures. Sits between the keypad/symbol front end and the actuator logic.

Parameters:
- N_DIGITS, 4, number of 2-bit digits per code; legal range 1..7.
- CODE, 8'b00_11_01_10, stored code; digit i = CODE[2*i+1:2*i], digit 0 entered first; width 2*N_DIGITS.
- MAX_FAIL, 3, consecutive failed sequences that trigger lockout; legal range 1..3.
- LOCKOUT_CYCLES, 16, lockout duration in clock cycles; legal range 1..256.

Ports:
- clk  in  1  single system clock, rising edge.
- reset  in  1  synchronous, active-high reset.
- sym_valid  in  1  qualifies sym for one cycle; one digit consumed per cycle it is high.
- sym  in  2  entered digit.
- clear  in  1  abandons the current partial entry.
- unlock  out  1  one-cycle pulse: correct full sequence entered.
- fail  out  1  one-cycle pulse: wrong full sequence entered.
- locked_out  out  1  high while in lockout.
- idx  out  3  number of digits consumed in the current attempt.
- fail_cnt  out  2  consecutive failed attempts since last success/lockout.

Behaviour:
- Reset: clk and reset as decided: one clock, synchronous active-high reset. On reset, state=ENTRY, idx=0, err=0, fail_cnt=0, timer=0, unlock=0, fail=0, locked_out=0. Reset overrides all inputs, including mid-lockout and mid-entry.
- Registering: all outputs are registered and change only on clk rising edge.
- Digit compare: match = (sym == CODE digit[idx]), with idx 3 bits.
- unlock and fail default to 0 every cycle unless set below.
- ENTRY state, priority order:
  - clear=1: idx<=0, err<=0. fail_cnt is unchanged and no pulse is issued. sym_valid is ignored that cycle.
  - sym_valid=1 and idx<N_DIGITS-1: idx<=idx+1; err<=err|~match.
  - sym_valid=1 and idx==N_DIGITS-1 (final digit): idx<=0 and err<=0, then one of:
    - Success (err==0 and match): unlock<=1, fail_cnt<=0.
    - Failure, fail_cnt+1<MAX_FAIL: fail<=1, fail_cnt<=fail_cnt+1.
    - Failure, fail_cnt+1==MAX_FAIL: fail<=1, fail_cnt<=0, state<=LOCKOUT, locked_out<=1, timer<=LOCKOUT_CYCLES-1.
  - No early abort on mismatch: all N_DIGITS digits are always consumed, so entry length gives no information.
- LOCKOUT state:
  - sym_valid and clear are ignored; idx stays 0.
  - timer==0: state<=ENTRY, locked_out<=0. Otherwise timer<=timer-1.
  - locked_out is high exactly LOCKOUT_CYCLES cycles, starting the cycle after the final wrong digit's edge. Symbols are accepted again on the first cycle locked_out reads 0.
- Back-to-back symbols (sym_valid held high) are legal; a new attempt may start the cycle after the final digit.
- Latency: unlock and fail are asserted in the cycle after the edge that samples the final digit. Each is exactly one cycle wide.
- N_DIGITS=1: every valid symbol is a complete attempt.
- Widths: timer is 8 bits; with LOCKOUT_CYCLES=256 it loads 255. idx never reaches N_DIGITS.

Test Plan:
- Correct entry: after reset, drive 2,1,3,0 on four consecutive sym_valid cycles -> idx steps 1,2,3,0; unlock=1 for exactly one cycle after the 4th digit; fail=0; fail_cnt=0.
- Wrong first digit: drive 3,1,3,0 -> unlock stays 0, fail pulses once, fail_cnt=1 after the 4th digit. A following correct 2,1,3,0 -> unlock pulses and fail_cnt returns to 0.
- Lockout: three wrong sequences (0,0,0,0 ×3) -> fail_cnt goes 1,2,0; locked_out=1 for exactly 16 cycles. Symbols 2,1,3,0 driven during lockout -> no unlock and idx stays 0. Correct entry after locked_out falls -> unlock pulses.
- Clear: drive 2,1, then clear=1 together with sym_valid=1 sym=3 -> idx=0, no fail pulse, fail_cnt unchanged. Then 2,1,3,0 -> unlock pulses.
- Reset mid-operation: pulse reset at timer=7 during lockout -> locked_out=0 next cycle. Also pulse reset with idx=2 -> idx=0, fail_cnt=0, and a subsequent 2,1,3,0 unlocks.
- Gapped input: 2,1,3,0 with sym_valid low for 5 idle cycles between each digit -> idx holds during gaps; unlock pulses once after the final digit.
